am2950_fifo_xcvr: RTL and testbench
===================================

Name: am2950_fifo_xcvr

Overview:
- Parametrised successor to the plain tristate bus transceiver: a registered, bidirectional bus transceiver in the Am2950 style.
- Two independent channels, each a DEPTH-entry FIFO with full/not-empty handshake flags:
  - R: captures port a, drives port b.
  - S: captures port b, drives port a.
- Sits between two tristate buses, e.g. CPU data bus and a microprogrammed peripheral bus, and decouples producer and consumer timing.

Parameters:
- WIDTH, 8, bus width in bits (>=1).
- DEPTH, 4, entries per channel FIFO; power of two, >=1. DEPTH=1 behaves as a classic single register with flag.

Ports:
- clk  input  1  single clock, all state changes on rising edge.
- rst_  input  1  reset, synchronous and active-low.
- a  inout  WIDTH  bus A; source for channel R, driven by channel S.
- b  inout  WIDTH  bus B; source for channel S, driven by channel R.
- ldr_  input  1  active-low load: push a into R.
- clrr_  input  1  active-low consume: pop R head.
- oeb_  input  1  active-low output enable: drive b with R head.
- lds_  input  1  active-low load: push b into S.
- clrs_  input  1  active-low consume: pop S head.
- oea_  input  1  active-low output enable: drive a with S head.
- fr  output  1  R not empty.
- fs  output  1  S not empty.
- fullr  output  1  R full.
- fulls  output  1  S full.

Behaviour:
- Reset (rst_ low at rising edge):
  - Pointers and counts cleared; storage cleared to 0.
  - fr=fs=fullr=fulls=0.
  - Reset overrides all strobes on that edge, including mid-transfer; buffered data is lost.
- Channels are identical and independent. The description below covers R; S mirrors it (b/lds_/clrs_/oea_/fs/fulls).
- push = !ldr_ && (!fullr || pop). The a pin value is sampled at the edge, including when this block drives a itself.
- pop = !clrr_ && fr.
- Simultaneous push and pop:
  - When non-empty: head advances, new word is written at tail, count unchanged. This is legal when full.
  - When empty: only push takes effect; count becomes 1.
- Push while full without pop: word dropped, state unchanged.
- Pop while empty: ignored.
- Flag timing:
  - fr = (count != 0).
  - fullr = (count == DEPTH).
  - Both are registered-state outputs and valid the cycle after the causing edge.
- Head data:
  - Storage[rd_ptr] while count>0; all zeros while empty.
  - First loaded word is visible on b after the load edge, given oeb_ low (1-edge latency).
- Tristate drive is combinational: b = oeb_ ? Z : R head; a = oea_ ? Z : S head. Output enables are independent of clk and reset; during reset with oeb_ low, b drives 0.
- Pointers wrap modulo DEPTH. With DEPTH=1 the pointers are constant 0 and only the count bit toggles.
- Count width is clog2(DEPTH)+1.

Optional Feature:
- Macro AM2950_OVERRUN_EN.
- With the macro defined:
  - Extra outputs ovrr and ovrs (1 bit each), cleared by reset.
  - Set sticky when a push is dropped: ldr_ low, fullr high, no pop.
  - Cleared by the next edge with clrr_ low (resp. clrs_); a simultaneous set takes priority over clear.
- Without the macro: ports absent, dropped pushes are silent.

Decomposition:
- Shared package am2950_pkg:
  - Function for pointer width: clog2, min 1.
  - Count width constant expression.
  - Localparam for all-zero head value.
- One natural sub-module am2950_chan (parametrised WIDTH, DEPTH):
  - Single-direction FIFO with ld_/clr_ inputs, din, head, nempty, full, optional ovr.
  - Instantiated twice.
- Top level holds only the tristate assigns and wiring.

Test Plan (WIDTH=8, DEPTH=4):
- Reset with ldr_/lds_ low and a=8'h5A: after edge, fr=fs=fullr=fulls=0; oeb_ low drives b=8'h00; oea_=oeb_=1 leaves a,b = Z.
- Push 8'h11, 8'h22, 8'h33, 8'h44 via ldr_ on 4 edges: fullr=1 after 4th edge. Fifth push of 8'h55 dropped (ovrr=1 with AM2950_OVERRUN_EN). Popping 4 times with oeb_ low shows b=11,22,33,44, then fr=0, b=00.
- Full R plus simultaneous ldr_/clrr_ with a=8'h66: count stays 4, fullr stays 1; subsequent pops yield 22,33,44,66.
- Empty S plus simultaneous lds_/clrs_ with b=8'hA5: fs=1, a=8'hA5 with oea_ low; next clrs_ edge makes fs=0.
- Concurrent traffic: R pushes 8'h0F while S pushes 8'hF0 in the same cycle. Channels are independent; swapping oea_/oeb_ gives a=F0, b=0F, no contention.
- Reset asserted while R holds 3 entries: next edge gives fr=0, fullr=0, b=00 with oeb_ low; ovrr cleared.

Source files
------------

// File: rtl/am2950_pkg.sv
// ---------------------------------------------------------------------------
// am2950_pkg
// Shared helpers for the Am2950-style registered bus transceiver.
//   ptr_width(depth) : FIFO pointer width, clog2(depth) with a floor of 1 bit
//   cnt_width(depth) : occupancy counter width, clog2(depth)+1 (holds 0..depth)
//   HEAD_FILL        : bit value replicated onto the head output while empty
// ---------------------------------------------------------------------------
package am2950_pkg;

  localparam logic HEAD_FILL = 1'b0;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/am2950_chan.sv
// ---------------------------------------------------------------------------
// am2950_chan
// One direction of the transceiver: a DEPTH-entry FIFO with handshake flags.
// Optional feature macro: AM2950_OVERRUN_EN (adds the sticky ovr flag).
// Ports:
//   clk     : clock, rising edge
//   rst_    : synchronous active-low reset
//   ld_     : active-low push of din
//   clr_    : active-low pop of the head entry
//   din     : data sampled on a push edge
//   head    : oldest entry, all zeros while empty
//   nempty  : FIFO holds at least one entry
//   full    : FIFO holds DEPTH entries
//   ovr     : sticky dropped-push flag (AM2950_OVERRUN_EN only)
// ---------------------------------------------------------------------------
module am2950_chan
  import am2950_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             ld_,
  input  logic             clr_,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             nempty,
  output logic             full
`ifdef AM2950_OVERRUN_EN
  ,
  output logic             ovr
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign nempty = (count != '0);
  assign full   = (count == CNT_FULL);

  // A full FIFO still accepts a word when the same edge frees a slot.
  assign pop  = !clr_ && nempty;
  assign push = !ld_ && (!full || pop);

  assign head = nempty ? mem[rd_ptr] : {WIDTH{HEAD_FILL}};

  // NOTE: reset clears storage too, so the head and the bus it drives are
  // defined right after reset rather than exposing stale contents.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge count/pointers, so push and pop on one edge do not interact.
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (DEPTH == 1) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (DEPTH == 1) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef AM2950_OVERRUN_EN
  // Set wins over clear; a set can only occur without a pop anyway.
  always_ff @(posedge clk) begin
    if (!rst_)                    ovr <= 1'b0;
    else if (!ld_ && full && !pop) ovr <= 1'b1;
    else if (!clr_)               ovr <= 1'b0;
  end
`endif

endmodule

// File: rtl/am2950_fifo_xcvr.sv
// ---------------------------------------------------------------------------
// am2950_fifo_xcvr
// Registered bidirectional bus transceiver with a FIFO per direction.
// Channel R captures bus a and drives bus b; channel S captures b, drives a.
// Optional feature macro: AM2950_OVERRUN_EN (adds ovrr / ovrs outputs).
// Ports:
//   clk, rst_          : clock, synchronous active-low reset
//   a, b               : tristate buses
//   ldr_, clrr_, oeb_  : R push / pop / drive-b enables (active low)
//   lds_, clrs_, oea_  : S push / pop / drive-a enables (active low)
//   fr, fs             : channel not empty
//   fullr, fulls       : channel full
//   ovrr, ovrs         : sticky dropped-push flags (AM2950_OVERRUN_EN only)
// ---------------------------------------------------------------------------
module am2950_fifo_xcvr #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  input  logic             ldr_,
  input  logic             clrr_,
  input  logic             oeb_,
  input  logic             lds_,
  input  logic             clrs_,
  input  logic             oea_,
  output logic             fr,
  output logic             fs,
  output logic             fullr,
  output logic             fulls
`ifdef AM2950_OVERRUN_EN
  ,
  output logic             ovrr,
  output logic             ovrs
`endif
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] s_head;

  // Output enables are purely combinational: they bypass clock and reset.
  assign b = oeb_ ? {WIDTH{1'bz}} : r_head;
  assign a = oea_ ? {WIDTH{1'bz}} : s_head;

  am2950_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_r (
    .clk    (clk),
    .rst_   (rst_),
    .ld_    (ldr_),
    .clr_   (clrr_),
    .din    (a),
    .head   (r_head),
    .nempty (fr),
    .full   (fullr)
`ifdef AM2950_OVERRUN_EN
    ,
    .ovr    (ovrr)
`endif
  );

  am2950_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_s (
    .clk    (clk),
    .rst_   (rst_),
    .ld_    (lds_),
    .clr_   (clrs_),
    .din    (b),
    .head   (s_head),
    .nempty (fs),
    .full   (fulls)
`ifdef AM2950_OVERRUN_EN
    ,
    .ovr    (ovrs)
`endif
  );

endmodule

// File: tb/tb_am2950_fifo_xcvr.sv
// ---------------------------------------------------------------------------
// tb_am2950_fifo_xcvr
// Table-driven bench for am2950_fifo_xcvr (WIDTH=8, DEPTH=4). Flag values
// come from the vector table; head data comes from per-channel queues that
// are filled when a push is driven and drained when a pop is driven.
// ---------------------------------------------------------------------------
module tb_am2950_fifo_xcvr;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_;
  logic ldr_, clrr_, oeb_, lds_, clrs_, oea_;
  logic fr, fs, fullr, fulls;
`ifdef AM2950_OVERRUN_EN
  logic ovrr, ovrs;
`endif

  logic [W-1:0] a_drv, b_drv;
  logic         a_en, b_en;
  wire  [W-1:0] a, b;

  assign a = a_en ? a_drv : {W{1'bz}};
  assign b = b_en ? b_drv : {W{1'bz}};

  always #5 clk = ~clk;

  am2950_fifo_xcvr #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_  (rst_),
    .a     (a),
    .b     (b),
    .ldr_  (ldr_),
    .clrr_ (clrr_),
    .oeb_  (oeb_),
    .lds_  (lds_),
    .clrs_ (clrs_),
    .oea_  (oea_),
    .fr    (fr),
    .fs    (fs),
    .fullr (fullr),
    .fulls (fulls)
`ifdef AM2950_OVERRUN_EN
    ,
    .ovrr  (ovrr),
    .ovrs  (ovrs)
`endif
  );

  typedef struct {
    string        name;
    logic         ldr_n, clrr_n, lds_n, clrs_n;
    logic [W-1:0] av, bv;
    logic         efr, efullr, efs, efulls, eovrr, eovrs;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] r_q[$];
  logic [W-1:0] s_q[$];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_strobes();
    ldr_ = 1'b1; clrr_ = 1'b1; lds_ = 1'b1; clrs_ = 1'b1;
  endtask

  // Release the bench drivers, enable one DUT driver at a time, compare
  // against the scoreboard head, then hand the buses back to the bench.
  task automatic check_heads(input string name);
    logic [W-1:0] exp_r, exp_s;
    exp_r = (r_q.size() > 0) ? r_q[0] : '0;
    exp_s = (s_q.size() > 0) ? s_q[0] : '0;
    b_en = 1'b0; oeb_ = 1'b0;
    #1 check({name, "/b_head"}, 32'(b), 32'(exp_r));
    oeb_ = 1'b1; b_en = 1'b1;
    a_en = 1'b0; oea_ = 1'b0;
    #1 check({name, "/a_head"}, 32'(a), 32'(exp_s));
    oea_ = 1'b1; a_en = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    bit pop_r, push_r, pop_s, push_s;
    @(negedge clk);
    ldr_ = v.ldr_n; clrr_ = v.clrr_n; lds_ = v.lds_n; clrs_ = v.clrs_n;
    a_drv = v.av; b_drv = v.bv; a_en = 1'b1; b_en = 1'b1;
    oea_ = 1'b1; oeb_ = 1'b1;
    pop_r  = !v.clrr_n && (r_q.size() > 0);
    push_r = !v.ldr_n && ((r_q.size() < D) || pop_r);
    pop_s  = !v.clrs_n && (s_q.size() > 0);
    push_s = !v.lds_n && ((s_q.size() < D) || pop_s);
    if (pop_r)  void'(r_q.pop_front());
    if (push_r) r_q.push_back(v.av);
    if (pop_s)  void'(s_q.pop_front());
    if (push_s) s_q.push_back(v.bv);
    @(negedge clk);
    idle_strobes();
    check({v.name, "/fr"},    32'(fr),    32'(v.efr));
    check({v.name, "/fullr"}, 32'(fullr), 32'(v.efullr));
    check({v.name, "/fs"},    32'(fs),    32'(v.efs));
    check({v.name, "/fulls"}, 32'(fulls), 32'(v.efulls));
`ifdef AM2950_OVERRUN_EN
    check({v.name, "/ovrr"},  32'(ovrr),  32'(v.eovrr));
    check({v.name, "/ovrs"},  32'(ovrs),  32'(v.eovrs));
`endif
    check_heads(v.name);
  endtask

  initial begin
    //             name          ldr  clrr lds  clrs a      b      fr fullr fs fulls ovrr ovrs
    vecs.push_back('{"push_r11",  0, 1, 1, 1, 8'h11, 8'h00, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{"push_r22",  0, 1, 1, 1, 8'h22, 8'h00, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{"push_r33",  0, 1, 1, 1, 8'h33, 8'h00, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{"push_r44",  0, 1, 1, 1, 8'h44, 8'h00, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{"drop_r55",  0, 1, 1, 1, 8'h55, 8'h00, 1, 1, 0, 0, 1, 0});
    vecs.push_back('{"pop_r1",    1, 0, 1, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{"pop_r2",    1, 0, 1, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{"pop_r3",    1, 0, 1, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{"pop_r4",    1, 0, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"pop_empty", 1, 0, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"refill11",  0, 1, 1, 1, 8'h11, 8'h00, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{"refill22",  0, 1, 1, 1, 8'h22, 8'h00, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{"refill33",  0, 1, 1, 1, 8'h33, 8'h00, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{"refill44",  0, 1, 1, 1, 8'h44, 8'h00, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{"full_pp66", 0, 0, 1, 1, 8'h66, 8'h00, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{"pop_22",    1, 0, 1, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{"pop_33",    1, 0, 1, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{"pop_44",    1, 0, 1, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{"pop_66",    1, 0, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"s_pp_a5",   1, 1, 0, 0, 8'h00, 8'hA5, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{"s_pop",     1, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"conc_0f_f0",0, 1, 0, 1, 8'h0F, 8'hF0, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{"r_push01",  0, 1, 1, 1, 8'h01, 8'h00, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{"r_push02",  0, 1, 1, 1, 8'h02, 8'h00, 1, 0, 1, 0, 0, 0});

    // Reset with loads asserted and a driven: nothing may be captured.
    rst_ = 1'b0;
    ldr_ = 1'b0; lds_ = 1'b0; clrr_ = 1'b1; clrs_ = 1'b1;
    oea_ = 1'b1; oeb_ = 1'b1;
    a_drv = 8'h5A; a_en = 1'b1;
    b_drv = 8'hC3; b_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst/fr",    32'(fr),    32'd0);
    check("rst/fs",    32'(fs),    32'd0);
    check("rst/fullr", 32'(fullr), 32'd0);
    check("rst/fulls", 32'(fulls), 32'd0);
`ifdef AM2950_OVERRUN_EN
    check("rst/ovrr",  32'(ovrr),  32'd0);
    check("rst/ovrs",  32'(ovrs),  32'd0);
`endif
    // Disabled outputs leave the bench's own values on the buses.
    check("rst/a_released", 32'(a), 32'h5A);
    check("rst/b_released", 32'(b), 32'hC3);
    // Enable works during reset and shows the cleared head.
    check_heads("rst");
    idle_strobes();
    rst_ = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Both channels now hold data: enable both outputs together.
    a_en = 1'b0; b_en = 1'b0;
    oea_ = 1'b0; oeb_ = 1'b0;
    #1;
    check("both_oe/a", 32'(a), 32'hF0);
    check("both_oe/b", 32'(b), 32'h0F);
    oea_ = 1'b1; oeb_ = 1'b1;
    a_en = 1'b1; b_en = 1'b1;

    // Mid-traffic reset with R holding 3 entries and a load pending.
    @(negedge clk);
    rst_ = 1'b0; ldr_ = 1'b0; lds_ = 1'b0; a_drv = 8'h77; b_drv = 8'h88;
    @(negedge clk);
    idle_strobes();
    r_q.delete();
    s_q.delete();
    check("rst2/fr",    32'(fr),    32'd0);
    check("rst2/fullr", 32'(fullr), 32'd0);
    check("rst2/fs",    32'(fs),    32'd0);
`ifdef AM2950_OVERRUN_EN
    check("rst2/ovrr",  32'(ovrr),  32'd0);
`endif
    check_heads("rst2");
    rst_ = 1'b1;

    // Life after reset: a single push shows up with one-edge latency.
    apply('{"post_rst_push", 0, 1, 1, 1, 8'h9C, 8'h00, 1, 0, 0, 0, 0, 0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Fixed-length run; this only guards against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected completion before 100000");
    $fatal(1);
  end

endmodule
